wb_la_initiator: RTL and testbench

//  Wishbone classic initiator driven by a simple command/response handshake (fed from LA bits or a test sequencer).

---
 rtl/wb_la_initiator_pkg.sv | 15 +
 rtl/wb_la_init_timer.sv | 33 +++
 rtl/wb_la_initiator.sv | 132 +++++++++++++
 tb/tb_wb_la_initiator.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_la_initiator_pkg.sv
// Shared types for the LA-driven Wishbone initiator.
// Holds the FSM state encoding and the width of the completed-transaction counter.
package wb_la_initiator_pkg;

    // Initiator sequencing: wait for a command, run one bus cycle, hand back a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of the completed-transaction counter (wraps from all-ones to zero).
    localparam int TX_COUNT_W = 16;

endpackage

// File: rtl/wb_la_init_timer.sv
// Saturating bus-cycle timer for the Wishbone initiator.
// The count holds the number of completed BUS cycles since the last clear, so
// 'expired' is raised during the LIMIT-th enabled cycle: the initiator then
// drops cyc/stb on the edge that ends that cycle, keeping the strobe up for
// exactly LIMIT cycles. The count saturates at LIMIT and never wraps.
module wb_la_init_timer #(
    parameter int LIMIT = 255,
    localparam int CW   = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);

    logic [CW-1:0] count;

    // Count enabled cycles, restarting on clear and holding once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/wb_la_initiator.sv
// Wishbone classic initiator driven by a command/response handshake.
// Issues one single read or write at a time to the user-project Wishbone
// target, returning read data (or zero) plus an error flag on the response
// side, and counts acknowledged transactions.
// Optional bus timeout: define WB_LA_INITIATOR_TIMEOUT_EN to abort a cycle
// that is not acknowledged within TIMEOUT_CYCLES cycles (rsp_err=1).
module wb_la_initiator
    import wb_la_initiator_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [AW-1:0]         cmd_adr,
    input  logic [DW-1:0]         cmd_dat,
    input  logic [DW/8-1:0]       cmd_sel,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_dat,
    output logic                  rsp_err,
    output logic [TX_COUNT_W-1:0] tx_count,
    // Wishbone initiator
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [AW-1:0]         wbm_adr_o,
    output logic [DW-1:0]         wbm_dat_o,
    output logic [DW/8-1:0]       wbm_sel_o,
    input  logic [DW-1:0]         wbm_dat_i,
    input  logic                  wbm_ack_i
);

    // A zero timeout would abort every cycle before the target can respond.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_la_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    logic   timeout;

    // Only one outstanding cycle: a new command is taken only while idle.
    assign cmd_ready = (state == IDLE);

`ifdef WB_LA_INITIATOR_TIMEOUT_EN
    // Timer runs only while a cycle is on the bus and restarts whenever we leave BUS.
    wb_la_init_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (state != BUS),
        .enable  (state == BUS),
        .expired (timeout)
    );
`else
    // Without the timeout feature the initiator waits for ack indefinitely.
    assign timeout = 1'b0;
`endif

    // Command latch, bus sequencing, response capture and transaction counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            tx_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state     <= BUS;
                    end
                end

                BUS: begin
                    // An ack arriving on the expiry cycle still completes normally.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        tx_count  <= tx_count + TX_COUNT_W'(1);
                        state     <= RESP;
                    end else if (timeout) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    // Response fields stay put until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_la_initiator.sv
// Self-checking bench for wb_la_initiator: a table of directed transactions,
// randomized transactions scored against a transaction-level model, and
// hand-written reset and counter-wrap sequences.
`timescale 1ns/1ps
module tb_wb_la_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int BUS_BOUND = 40;
`ifdef WB_LA_INITIATOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic [15:0]   tx_count;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [SW-1:0] wbm_sel_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;

    always #5 clk = ~clk;

    wb_la_initiator #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .tx_count  (tx_count),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            delay;    // wait cycles before the target acks
        logic [DW-1:0] rdata;    // data the target returns with ack
        int            wait_c;   // cycles rsp_ready is held low
        logic [DW-1:0] exp_dat;
        bit            exp_err;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] m_tx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a cycle either completes when the target
    // acks, or (with the timeout feature) is abandoned after TO unacked cycles.
    function automatic void model_rsp(input bit we, input int delay, input logic [DW-1:0] rdata,
                                      output logic [DW-1:0] dat, output bit err, output int bus_cycles);
        err        = TO_EN && (delay >= TO);
        bus_cycles = err ? TO : delay + 1;
        dat        = (we || err) ? '0 : rdata;
    endfunction

    task automatic do_txn(input vec_t v);
        logic [DW-1:0] m_dat;
        bit            m_err;
        int            exp_cycles;
        int            cycles;
        bit            done;
        bit            ok;
        model_rsp(v.we, v.delay, v.rdata, m_dat, m_err, exp_cycles);
        // offer the command
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        cmd_sel   = SW'($urandom);
        chk("cyc_start", wbm_cyc_o, 1);
        chk("stb_start", wbm_stb_o, 1);
        chk("we_start", wbm_we_o, v.we);
        chk("adr_start", wbm_adr_o, v.adr);
        chk("dat_start", wbm_dat_o, v.dat);
        chk("sel_start", wbm_sel_o, v.sel);
        chk("cmd_ready_bus", cmd_ready, 0);
        // bus phase: the target acks after v.delay wait cycles
        cycles = 0;
        done   = 1'b0;
        ok     = 1'b1;
        while (!done && cycles < BUS_BOUND) begin
            cycles++;
            if (cycles > v.delay) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.rdata;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            @(negedge clk);
            wbm_ack_i = 1'b0;
            if (!wbm_cyc_o) begin
                done = 1'b1;
            end else begin
                ok &= (wbm_stb_o === 1'b1) && (wbm_we_o === v.we) && (wbm_adr_o === v.adr)
                      && (wbm_dat_o === v.dat) && (wbm_sel_o === v.sel) && (cmd_ready === 1'b0);
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL bus_bound: cyc still high after %0d cycles, expected drop after %0d", cycles, exp_cycles);
        end
        chk("bus_stable", ok, 1);
        chk("bus_cycles", cycles, exp_cycles);
        chk("m_err", m_err, v.exp_err);
        if (!v.exp_err) m_tx = m_tx + 16'd1;
        chk("stb_end", wbm_stb_o, 0);
        chk("we_end", wbm_we_o, 0);
        chk("adr_held", wbm_adr_o, v.adr);
        chk("sel_held", wbm_sel_o, v.sel);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("tx_count", tx_count, m_tx);
        chk("cmd_ready_resp", cmd_ready, 0);
        // response backpressure, with a competing command and stray acks
        ok = 1'b1;
        for (int i = 0; i < v.wait_c; i++) begin
            cmd_valid = 1'b1;
            wbm_ack_i = 1'($urandom_range(0, 1));
            wbm_dat_i = $urandom;
            @(negedge clk);
            ok &= (rsp_valid === 1'b1) && (rsp_dat === v.exp_dat) && (rsp_err === v.exp_err)
                  && (cmd_ready === 1'b0) && (wbm_cyc_o === 1'b0) && (tx_count === m_tx);
        end
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        if (v.wait_c > 0) chk("backpressure_stable", ok, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        chk("no_second_cmd", wbm_cyc_o, 0);
    endtask

    task automatic rand_txn();
        vec_t v;
        bit   e;
        int   c;
        v.we     = 1'($urandom_range(0, 1));
        v.adr    = $urandom;
        v.dat    = $urandom;
        v.sel    = SW'($urandom);
        v.delay  = $urandom_range(0, 6);
        v.rdata  = $urandom;
        v.wait_c = $urandom_range(0, 3);
        model_rsp(v.we, v.delay, v.rdata, v.exp_dat, e, c);
        v.exp_err = e;
        do_txn(v);
    endtask

    vec_t vt[6];

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'hDEAD_BEEF, 0, 32'h0, 1'b0};
        vt[1] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, 0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0};
        vt[2] = '{1'b0, 32'h3000_0010, 32'h1111_1111, 4'h3, 1, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
        vt[3] = '{1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'h8, TO - 1, 32'h7777_7777, 2, 32'h0, 1'b0};
        vt[4] = '{1'b0, 32'h3000_0030, 32'h0, 4'hF, 9, 32'h1111_2222, 1,
                  TO_EN ? 32'h0 : 32'h1111_2222, TO_EN};
        vt[5] = '{1'b0, 32'h3000_0040, 32'h0, 4'hC, TO - 1, 32'hFEED_0001, 0, 32'hFEED_0001, 1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        m_tx      = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_we", wbm_we_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_tx_count", tx_count, 0);

        // directed table
        for (int i = 0; i < 6; i++) do_txn(vt[i]);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) rand_txn();

        // reset while a cycle is on the bus, then a late ack
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0100;
        cmd_dat   = 32'h0BAD_F00D;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rstbus_stb_before", wbm_stb_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_tx = 16'd0;
        chk("rstbus_cyc", wbm_cyc_o, 0);
        chk("rstbus_stb", wbm_stb_o, 0);
        chk("rstbus_rsp_valid", rsp_valid, 0);
        chk("rstbus_cmd_ready", cmd_ready, 1);
        chk("rstbus_tx_count", tx_count, 0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h9999_9999;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk("late_ack_cyc", wbm_cyc_o, 0);
        chk("late_ack_rsp_valid", rsp_valid, 0);
        chk("late_ack_tx_count", tx_count, 0);

        // a normal transaction after the reset
        do_txn(vt[2]);

        // counter wrap: preload one below all-ones, then complete two cycles
        @(negedge clk);
        force dut.tx_count = 16'hFFFE;
        @(negedge clk);
        release dut.tx_count;
        m_tx = 16'hFFFE;
        chk("wrap_preload", tx_count, 16'hFFFE);
        do_txn(vt[0]);
        do_txn(vt[1]);
        chk("wrap_zero", tx_count, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
